stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/adjust sequencer for the stopwatch time counters. Debounces the start and clear
//  buttons, runs the STOP/RUN/PAUSE/ADJ/DONE state machine and drives the per-cycle clock
//  enables, clear and direction of the seconds/minutes counters. Sits between the clock
//  divider (tick inputs) and the two time_counter instances; it replaces ad-hoc top-level glue.
// PARAMETERS
//  DEB_SAMPLES  4  consecutive equal tick_500hz samples needed to accept a button level change
//  DEB_W        3  width of the debounce sample counter (must hold DEB_SAMPLES-1)
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  rst         in   1  asynchronous, active-high reset
//  tick_1hz    in   1  1-cycle enable pulse, 1 Hz
//  tick_2hz    in   1  1-cycle enable pulse, 2 Hz
//  tick_500hz  in   1  1-cycle enable pulse, 500 Hz (debounce sample strobe)
//  btn_start   in   1  raw start/pause button, asynchronous to clk
//  btn_clear   in   1  raw clear button, asynchronous to clk
//  sw_adj      in   1  1 = request adjust mode
//  sw_sel      in   1  adjust target: 0 = seconds, 1 = minutes
//  sw_down     in   1  1 = count down
//  sec_term    in   1  seconds counter at terminal value (59 counting up, 00 counting down)
//  at_zero     in   1  all four digits are 0
//  sec_en      out  1  seconds counter clock enable
//  min_en      out  1  minutes counter clock enable
//  cnt_clr     out  1  1-cycle synchronous clear to both counters
//  back        out  1  count direction to both counters (1 = down)
//  running     out  1  state == RUN
//  done_blink  out  1  toggles at 2 Hz while in DONE, else 0
// BEHAVIOUR
//  - Reset: state=STOP; every output 0; debounced levels 0; sync flops and sample counters 0.
//  - Buttons: 2-FF synchroniser each. On tick_500hz, a sample differing from the debounced
//    level increments the sample counter and an equal sample zeroes it. When the counter
//    reaches DEB_SAMPLES the level flips. A 0->1 flip of the level yields a 1-clk event
//    (start_evt / clear_evt) in the cycle after the flip. Release generates no event.
//  - All outputs are registered. An enable is asserted exactly 1 clk after its source tick.
//  - Transitions, evaluated in priority order each clk:
//    1. clear_evt: any state -> STOP. cnt_clr=1 for 1 clk. Beats start_evt in the same cycle.
//    2. STOP  + start_evt -> RUN.  STOP  + sw_adj=1 -> ADJ.
//    3. RUN   + start_evt -> PAUSE. sw_adj, sw_sel and sw_down are ignored in RUN.
//    4. RUN, back=1, at_zero=1, tick_1hz -> DONE. sec_en/min_en stay 0 on that tick.
//    5. PAUSE + start_evt -> RUN.  PAUSE + sw_adj=1 -> ADJ.
//    6. ADJ   + sw_adj=0 -> PAUSE. start_evt is ignored in ADJ.
//    7. DONE: only clear_evt leaves DONE.
//  - back is loaded from sw_down only while in STOP, PAUSE or ADJ and is held through RUN/DONE.
//    A direction change therefore never lands mid-run.
//  - RUN: sec_en <= tick_1hz; min_en <= tick_1hz & sec_term (carry/borrow). 00:00 counting up
//    after 59:59 wraps inside the counters; the controller takes no action.
//  - ADJ: sw_sel=0 gives sec_en <= tick_2hz and min_en=0. sw_sel=1 gives min_en <= tick_2hz
//    and sec_en=0. There is no carry in ADJ.
//  - STOP/PAUSE/DONE: sec_en=min_en=0.
//  - Entering DONE: done_blink <= 1, then toggles on each tick_2hz. Leaving DONE forces it to 0.
//  - A tick coinciding with a transition event is evaluated against the NEW state. A tick on
//    the same clk as RUN->PAUSE is dropped; a tick on the same clk as PAUSE->RUN is honoured.
//  - rst asserted mid-operation returns every register to its reset value immediately.
//    Counters are cleared separately via the shared reset.
// TESTING
//  1. Hold btn_start 1 for 3 tick_500hz then drop -> no start_evt. Hold for 4 -> exactly one
//     start_evt, state RUN.
//  2. RUN, sw_down=0, sec_term=1 on tick_1hz -> sec_en=1 and min_en=1 one clk later.
//     sec_term=0 -> only sec_en.
//  3. PAUSE, sw_adj=1, sw_sel=1, 4 tick_2hz -> 4 min_en pulses, 0 sec_en. sw_adj=0 -> PAUSE.
//  4. RUN, back=1, at_zero=1, tick_1hz -> DONE with no enable pulse. done_blink toggles on
//     each tick_2hz. clear_evt -> STOP, cnt_clr 1 clk, done_blink=0.
//  5. start_evt and clear_evt in the same clk from RUN -> STOP with cnt_clr=1, not PAUSE.
//  6. Toggle sw_down during RUN -> back unchanged. Pause -> back follows sw_down.
//     rst pulse mid-RUN -> state STOP, all outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust sequencer for the stopwatch seconds/minutes counters.
// Debounces start/clear, runs the STOP/RUN/PAUSE/ADJ/DONE machine and drives registered enables.
module stopwatch_ctrl #(
    parameter int DEB_SAMPLES = 4,
    parameter int DEB_W       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1hz,
    input  logic tick_2hz,
    input  logic tick_500hz,
    input  logic btn_start,
    input  logic btn_clear,
    input  logic sw_adj,
    input  logic sw_sel,
    input  logic sw_down,
    input  logic sec_term,
    input  logic at_zero,
    output logic sec_en,
    output logic min_en,
    output logic cnt_clr,
    output logic back,
    output logic running,
    output logic done_blink
);

    typedef enum logic [2:0] {
        ST_STOP,
        ST_RUN,
        ST_PAUSE,
        ST_ADJ,
        ST_DONE
    } state_t;

    // Index 0 = start button, index 1 = clear button.
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            level_q, level_d;
    logic [1:0]            evt_q, evt_d;
    logic [1:0][DEB_W-1:0] cnt_q, cnt_d;

    assign btn_raw = {btn_clear, btn_start};

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        evt_d   = '0;
        for (int i = 0; i < 2; i++) begin
            if (tick_500hz) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == DEB_W'(DEB_SAMPLES - 1)) begin
                        level_d[i] = ~level_q[i];
                        cnt_d[i]   = '0;
                        evt_d[i]   = ~level_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + DEB_W'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            evt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    logic   start_evt, clear_evt;
    state_t state_q, state_d;
    logic   sec_en_q, sec_en_d, min_en_q, min_en_d, cnt_clr_q, cnt_clr_d;
    logic   back_q, back_d, running_q, running_d, blink_q, blink_d;

    assign start_evt = evt_q[0];
    assign clear_evt = evt_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STOP;
            sec_en_q  <= 1'b0;
            min_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            back_q    <= 1'b0;
            running_q <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_en_q  <= sec_en_d;
            min_en_q  <= min_en_d;
            cnt_clr_q <= cnt_clr_d;
            back_q    <= back_d;
            running_q <= running_d;
            blink_q   <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_evt) begin
            state_d = ST_STOP;
        end else begin
            unique case (state_q)
                ST_STOP:  if (start_evt) state_d = ST_RUN;
                          else if (sw_adj) state_d = ST_ADJ;
                ST_RUN:   if (start_evt) state_d = ST_PAUSE;
                          else if (back_q && at_zero && tick_1hz) state_d = ST_DONE;
                ST_PAUSE: if (start_evt) state_d = ST_RUN;
                          else if (sw_adj) state_d = ST_ADJ;
                ST_ADJ:   if (!sw_adj) state_d = ST_PAUSE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_STOP;
            endcase
        end
    end

    // NOTE: outputs decode state_d so a tick landing on a transition sees the new state.
    always_comb begin
        sec_en_d  = 1'b0;
        min_en_d  = 1'b0;
        cnt_clr_d = clear_evt;
        running_d = (state_d == ST_RUN);
        blink_d   = 1'b0;
        back_d    = back_q;
        if (state_q == ST_STOP || state_q == ST_PAUSE || state_q == ST_ADJ) begin
            back_d = sw_down;
        end
        unique case (state_d)
            ST_RUN: begin
                sec_en_d = tick_1hz;
                min_en_d = tick_1hz & sec_term;
            end
            ST_ADJ: begin
                sec_en_d = tick_2hz & ~sw_sel;
                min_en_d = tick_2hz & sw_sel;
            end
            ST_DONE: blink_d = (state_q != ST_DONE) ? 1'b1 : (blink_q ^ tick_2hz);
            default: ;
        endcase
    end

    assign sec_en     = sec_en_q;
    assign min_en     = min_en_q;
    assign cnt_clr    = cnt_clr_q;
    assign back       = back_q;
    assign running    = running_q;
    assign done_blink = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus a randomized run against a mode-level model.
module tb_stopwatch_ctrl;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_1hz = 0, tick_2hz = 0, tick_500hz = 0;
    logic btn_start = 0, btn_clear = 0;
    logic sw_adj = 0, sw_sel = 0, sw_down = 0, sec_term = 0, at_zero = 0;
    logic sec_en, min_en, cnt_clr, back, running, done_blink;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.DEB_SAMPLES(DEB), .DEB_W(3)) dut (
        .clk(clk), .rst(rst),
        .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_500hz(tick_500hz),
        .btn_start(btn_start), .btn_clear(btn_clear),
        .sw_adj(sw_adj), .sw_sel(sw_sel), .sw_down(sw_down),
        .sec_term(sec_term), .at_zero(at_zero),
        .sec_en(sec_en), .min_en(min_en), .cnt_clr(cnt_clr),
        .back(back), .running(running), .done_blink(done_blink)
    );

    always #5 clk = ~clk;

    // Reference model: mode, held direction, and per-button sample history.
    typedef enum {M_STOP, M_RUN, M_PAUSE, M_ADJ, M_DONE} mode_t;
    mode_t m_mode;
    bit    m_back;
    bit    m_hist1 [2];
    bit    m_hist2 [2];
    bit    m_lvl   [2];
    int    m_diff  [2];
    bit    m_evt   [2];
    bit    e_sec, e_min, e_clr, e_run, e_blink;

    task automatic model_reset();
        m_mode = M_STOP;
        m_back = 0;
        e_sec = 0; e_min = 0; e_clr = 0; e_run = 0; e_blink = 0;
        for (int i = 0; i < 2; i++) begin
            m_hist1[i] = 0; m_hist2[i] = 0; m_lvl[i] = 0; m_diff[i] = 0; m_evt[i] = 0;
        end
    endtask

    task automatic model_step();
        mode_t nm;
        bit st, cl, raw;
        if (rst) begin
            model_reset();
            return;
        end
        st = m_evt[0];
        cl = m_evt[1];
        nm = m_mode;
        if (cl) nm = M_STOP;
        else begin
            case (m_mode)
                M_STOP:  nm = st ? M_RUN : (sw_adj ? M_ADJ : M_STOP);
                M_RUN:   nm = st ? M_PAUSE : ((m_back && at_zero && tick_1hz) ? M_DONE : M_RUN);
                M_PAUSE: nm = st ? M_RUN : (sw_adj ? M_ADJ : M_PAUSE);
                M_ADJ:   nm = sw_adj ? M_ADJ : M_PAUSE;
                default: nm = M_DONE;
            endcase
        end
        e_sec   = (nm == M_RUN && tick_1hz) || (nm == M_ADJ && !sw_sel && tick_2hz);
        e_min   = (nm == M_RUN && tick_1hz && sec_term) || (nm == M_ADJ && sw_sel && tick_2hz);
        e_clr   = cl;
        e_run   = (nm == M_RUN);
        e_blink = (nm != M_DONE) ? 0 : ((m_mode != M_DONE) ? 1 : (e_blink ^ tick_2hz));
        if (m_mode == M_STOP || m_mode == M_PAUSE || m_mode == M_ADJ) m_back = sw_down;
        m_mode = nm;
        for (int i = 0; i < 2; i++) begin
            raw = (i == 0) ? btn_start : btn_clear;
            m_evt[i] = 0;
            if (tick_500hz) begin
                if (m_hist2[i] != m_lvl[i]) begin
                    m_diff[i] = m_diff[i] + 1;
                    if (m_diff[i] >= DEB) begin
                        m_lvl[i]  = !m_lvl[i];
                        m_diff[i] = 0;
                        m_evt[i]  = m_lvl[i];
                    end
                end else begin
                    m_diff[i] = 0;
                end
            end
            m_hist2[i] = m_hist1[i];
            m_hist1[i] = raw;
        end
    endtask

    // Advance one clock; the model sees the same inputs the DUT samples; ticks are 1-cycle pulses.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        tick_1hz   = 0;
        tick_2hz   = 0;
        tick_500hz = 0;
    endtask

    task automatic press(input bit s, input bit c, input int n);
        btn_start = s;
        btn_clear = c;
        repeat (3) cycle();
        repeat (n) begin
            tick_500hz = 1;
            cycle();
            cycle();
        end
    endtask

    task automatic release_btns();
        btn_start = 0;
        btn_clear = 0;
        repeat (3) cycle();
        repeat (DEB) begin
            tick_500hz = 1;
            cycle();
            cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1;
        model_reset();
        repeat (3) cycle();
        checks++;
        if ({sec_en, min_en, cnt_clr, back, running, done_blink} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 000000",
                     {sec_en, min_en, cnt_clr, back, running, done_blink});
        end
        rst = 0;
        repeat (2) cycle();
        checks++;
        if ({sec_en, min_en, cnt_clr, back, running, done_blink} !== 6'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b, want 000000",
                     {sec_en, min_en, cnt_clr, back, running, done_blink});
        end
    endtask

    task automatic test_debounce();
        press(1, 0, DEB - 1);
        release_btns();
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL debounce_short: running=%b, want 0", running);
        end
        press(1, 0, DEB);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL debounce_full: running=%b, want 1", running);
        end
        release_btns();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL debounce_release: running=%b, want 1 (no event on release)", running);
        end
    endtask

    task automatic test_run_carry();
        sec_term = 1;
        tick_1hz = 1;
        checks++;
        if ({sec_en, min_en} !== 2'b00) begin
            errors++;
            $display("FAIL carry_pre_tick: sec/min=%b, want 00", {sec_en, min_en});
        end
        cycle();
        checks++;
        if ({sec_en, min_en} !== 2'b11) begin
            errors++;
            $display("FAIL carry_tick: sec/min=%b, want 11", {sec_en, min_en});
        end
        cycle();
        checks++;
        if ({sec_en, min_en} !== 2'b00) begin
            errors++;
            $display("FAIL carry_one_cycle: sec/min=%b, want 00", {sec_en, min_en});
        end
        sec_term = 0;
        tick_1hz = 1;
        cycle();
        checks++;
        if ({sec_en, min_en} !== 2'b10) begin
            errors++;
            $display("FAIL no_carry_tick: sec/min=%b, want 10", {sec_en, min_en});
        end
        cycle();
    endtask

    task automatic test_adjust();
        int n_sec = 0;
        int n_min = 0;
        press(1, 0, DEB);
        release_btns();
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL pause_entry: running=%b, want 0", running);
        end
        sw_adj = 1;
        sw_sel = 1;
        cycle();
        for (int k = 0; k < 4; k++) begin
            tick_2hz = 1;
            cycle();
            n_sec += int'(sec_en);
            n_min += int'(min_en);
            cycle();
            n_sec += int'(sec_en);
            n_min += int'(min_en);
        end
        checks++;
        if (n_min != 4 || n_sec != 0) begin
            errors++;
            $display("FAIL adj_minutes: min pulses=%0d sec pulses=%0d, want 4 and 0", n_min, n_sec);
        end
        press(1, 0, DEB);
        release_btns();
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL adj_ignores_start: running=%b, want 0", running);
        end
        sw_adj = 0;
        sw_sel = 0;
        cycle();
        press(1, 0, DEB);
        release_btns();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL adj_exit_to_pause: running=%b, want 1 after start", running);
        end
    endtask

    task automatic test_done();
        press(1, 0, DEB);
        release_btns();
        sw_down = 1;
        repeat (2) cycle();
        checks++;
        if (back !== 1'b1) begin
            errors++;
            $display("FAIL back_load_pause: back=%b, want 1", back);
        end
        press(1, 0, DEB);
        release_btns();
        at_zero  = 1;
        tick_1hz = 1;
        cycle();
        checks++;
        if ({sec_en, min_en, running, done_blink} !== 4'b0001) begin
            errors++;
            $display("FAIL done_entry: sec,min,run,blink=%b, want 0001",
                     {sec_en, min_en, running, done_blink});
        end
        tick_2hz = 1;
        cycle();
        checks++;
        if (done_blink !== 1'b0) begin
            errors++;
            $display("FAIL blink_toggle1: blink=%b, want 0", done_blink);
        end
        cycle();
        tick_2hz = 1;
        cycle();
        checks++;
        if (done_blink !== 1'b1) begin
            errors++;
            $display("FAIL blink_toggle2: blink=%b, want 1", done_blink);
        end
        press(0, 1, DEB);
        checks++;
        if ({cnt_clr, running, done_blink} !== 3'b100) begin
            errors++;
            $display("FAIL done_clear: clr,run,blink=%b, want 100", {cnt_clr, running, done_blink});
        end
        cycle();
        checks++;
        if (cnt_clr !== 1'b0) begin
            errors++;
            $display("FAIL clr_one_cycle: cnt_clr=%b, want 0", cnt_clr);
        end
        release_btns();
        at_zero = 0;
        sw_down = 0;
        repeat (2) cycle();
    endtask

    task automatic test_same_cycle();
        press(1, 0, DEB);
        release_btns();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_setup: running=%b, want 1", running);
        end
        press(1, 1, DEB);
        checks++;
        if ({cnt_clr, running} !== 2'b10) begin
            errors++;
            $display("FAIL clear_beats_start: clr,run=%b, want 10", {cnt_clr, running});
        end
        release_btns();
    endtask

    task automatic test_direction();
        press(1, 0, DEB);
        release_btns();
        for (int k = 0; k < 6; k++) begin
            sw_down = ~sw_down;
            cycle();
            checks++;
            if (back !== 1'b0) begin
                errors++;
                $display("FAIL back_held_run: back=%b, want 0 (step %0d)", back, k);
            end
        end
        sw_down = 1;
        press(1, 0, DEB);
        release_btns();
        checks++;
        if (back !== 1'b1) begin
            errors++;
            $display("FAIL back_follow_pause: back=%b, want 1", back);
        end
        sw_down = 0;
        repeat (2) cycle();
        checks++;
        if (back !== 1'b0) begin
            errors++;
            $display("FAIL back_follow_pause0: back=%b, want 0", back);
        end
        press(1, 0, DEB);
        release_btns();
        tick_1hz = 1;
        cycle();
        checks++;
        if ({sec_en, running} !== 2'b11) begin
            errors++;
            $display("FAIL pre_rst_run: sec,run=%b, want 11", {sec_en, running});
        end
        #2;
        rst = 1;
        #1;
        checks++;
        if ({sec_en, min_en, cnt_clr, back, running, done_blink} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b, want 000000",
                     {sec_en, min_en, cnt_clr, back, running, done_blink});
        end
        model_reset();
        cycle();
        rst = 0;
        cycle();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 3000; n++) begin
            tick_500hz = ($urandom_range(3) == 0);
            tick_1hz   = ($urandom_range(15) == 0);
            tick_2hz   = ($urandom_range(7) == 0);
            if ($urandom_range(39) == 0) btn_start = ~btn_start;
            if ($urandom_range(79) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(49) == 0) sw_adj = ~sw_adj;
            if ($urandom_range(19) == 0) sw_sel = ~sw_sel;
            if ($urandom_range(29) == 0) sw_down = ~sw_down;
            sec_term = ($urandom_range(2) == 0);
            at_zero  = ($urandom_range(3) == 0);
            rst      = ($urandom_range(1499) == 0);
            cycle();
            checks++;
            if ({sec_en, min_en, cnt_clr, back, running, done_blink} !==
                {e_sec, e_min, e_clr, m_back, e_run, e_blink}) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle %0d: sec,min,clr,back,run,blink=%b, model=%b", n,
                             {sec_en, min_en, cnt_clr, back, running, done_blink},
                             {e_sec, e_min, e_clr, m_back, e_run, e_blink});
            end
        end
        rst = 0;
        cycle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_debounce();
        test_run_carry();
        test_adjust();
        test_done();
        test_same_cycle();
        test_direction();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
